// File: rtl/output_mem_if.sv
// APB slave port plus a byte-wide AXI-Stream sink port for the receive buffer.
// master drives requests and stream beats; slave answers with APB data and tready.
interface output_mem_if;
  logic [31:0] S_APB_paddr;
  logic        S_APB_psel;
  logic        S_APB_penable;
  logic        S_APB_pwrite;
  logic [31:0] S_APB_pwdata;
  logic [31:0] S_APB_prdata;
  logic        S_APB_pready;
  logic        S_APB_pslverr;
  logic [7:0]  S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tkeep;
  logic        S_AXIS_tlast;
  logic        S_AXIS_tready;

  modport master (
    output S_APB_paddr, S_APB_psel, S_APB_penable, S_APB_pwrite, S_APB_pwdata,
    input  S_APB_prdata, S_APB_pready, S_APB_pslverr,
    output S_AXIS_tdata, S_AXIS_tvalid, S_AXIS_tkeep, S_AXIS_tlast,
    input  S_AXIS_tready
  );

  modport slave (
    input  S_APB_paddr, S_APB_psel, S_APB_penable, S_APB_pwrite, S_APB_pwdata,
    output S_APB_prdata, S_APB_pready, S_APB_pslverr,
    input  S_AXIS_tdata, S_AXIS_tvalid, S_AXIS_tkeep, S_AXIS_tlast,
    output S_AXIS_tready
  );
endinterface

// File: rtl/output_mem.sv
// Captures one byte-stream frame (up to 4096 bytes) into a 1024x32 buffer readable over APB.
// Latency: stream byte lands in the buffer on its handshake edge; APB accesses take one wait state.
// Backpressure: tready is simply "receiving"; excess bytes past 4096 are accepted and dropped.
module output_mem #(
  parameter logic [19:0] MEM_BASE = 20'h43C10,
  parameter logic [19:0] REG_BASE = 20'h43C11
) (
  input  logic              S_APB_aclk,
  input  logic              S_APB_aresetn,
  output_mem_if.slave       bus,
  input  logic              Rcv_start,
  output logic              Busy,
  output logic              Done,
  output logic [12:0]       Rcv_Length
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  start_sync;
  logic        start_rise;
  logic        overflow;
  logic [3:0][7:0] mem [1024];

  // APB decode
  logic        apb_acc;
  logic [19:0] page;
  logic [11:0] off;
  logic        mem_hit, reg_hit;
  logic        is_status, is_length, is_ctrl;
  logic        apb_err;
  logic        ctrl_wr, arm, clr;
  logic        hs, full, store;
  logic [31:0] rd_val;
  logic        unused;

  assign page      = bus.S_APB_paddr[31:12];
  assign off       = bus.S_APB_paddr[11:0];
  assign mem_hit   = (page == MEM_BASE);
  assign reg_hit   = (page == REG_BASE);
  assign is_status = reg_hit && (off == 12'h000);
  assign is_length = reg_hit && (off == 12'h004);
  assign is_ctrl   = reg_hit && (off == 12'h008);
  // pready doubles as the "already answered" flag, so each access gets exactly one wait state
  assign apb_acc   = bus.S_APB_psel && bus.S_APB_penable && !bus.S_APB_pready;

  // Writes only land on CTRL; reads are fine anywhere inside the two pages
  assign apb_err = bus.S_APB_pwrite ? (!reg_hit || is_status || is_length)
                                    : (!reg_hit && !mem_hit);

  assign ctrl_wr = apb_acc && bus.S_APB_pwrite && is_ctrl;
  assign start_rise = start_sync[1] && !start_sync[2];
  assign arm     = start_rise || (ctrl_wr && bus.S_APB_pwdata[0]);
  // arm takes priority when both bits are written together
  assign clr     = ctrl_wr && bus.S_APB_pwdata[1] && !bus.S_APB_pwdata[0];

  assign hs    = bus.S_AXIS_tvalid && (state == RECV);
  assign full  = Rcv_Length[12];  // length never exceeds 4096, so bit 12 alone means full
  assign store = hs && bus.S_AXIS_tkeep && !full;

  assign bus.S_AXIS_tready = (state == RECV);
  assign Busy = (state == RECV);
  assign Done = (state == DONE);

  assign unused = ^{1'b0, bus.S_APB_pwdata[31:2]};

  // Synchronise Rcv_start and keep one extra stage for edge detection
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) start_sync <= 3'b000;
    else                start_sync <= {start_sync[1:0], Rcv_start};
  end

  // State register
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next-state logic: arm is ignored while receiving, clear only acts in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arm) state_nxt = RECV;
      RECV: if (hs && bus.S_AXIS_tlast) state_nxt = DONE;
      DONE: begin
        if (arm)      state_nxt = RECV;
        else if (clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte counter and overflow flag; overflow marks a byte dropped because the buffer is full
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      Rcv_Length <= 13'd0;
      overflow   <= 1'b0;
    end else if (arm && state != RECV) begin
      Rcv_Length <= 13'd0;
      overflow   <= 1'b0;
    end else if (store) begin
      Rcv_Length <= Rcv_Length + 13'd1;
    end else if (hs && bus.S_AXIS_tkeep && full) begin
      overflow   <= 1'b1;
    end
  end

  // Buffer write port: byte n goes to word n/4, lane n%4; contents survive reset
  always_ff @(posedge S_APB_aclk) begin
    if (store) mem[Rcv_Length[11:2]][Rcv_Length[1:0]] <= bus.S_AXIS_tdata;
  end

  // Read-data mux feeding the registered prdata
  always_comb begin
    rd_val = 32'd0;
    if (!bus.S_APB_pwrite && !apb_err) begin
      if (mem_hit)        rd_val = mem[bus.S_APB_paddr[11:2]];
      else if (is_status) rd_val = {29'd0, overflow, Done, Busy};
      else if (is_length) rd_val = {19'd0, Rcv_Length};
    end
  end

  // APB response registers: one-cycle pready with data and error alongside
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      bus.S_APB_pready  <= 1'b0;
      bus.S_APB_pslverr <= 1'b0;
      bus.S_APB_prdata  <= 32'd0;
    end else begin
      bus.S_APB_pready  <= apb_acc;
      bus.S_APB_pslverr <= apb_acc && apb_err;
      if (apb_acc) bus.S_APB_prdata <= rd_val;
    end
  end

endmodule
